// File: rtl/lost_chanbank.sv
// lost_chanbank: NCHAN synchronised, glitch-filtered edge loggers merged round-robin into one timestamped FIFO.
// Define LOST_DROPCNT_EN to add per-channel saturating drop counters (dropsel/dropcnt).

module lost_chan #(
    parameter int FILT_LEN = 3,
    parameter int TSW      = 60
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           din,
    input  logic [1:0]     mode,
    input  logic [TSW-1:0] ts,
    input  logic           startup_evt,
    input  logic           det_en,
    input  logic           grant,
    output logic           pend_v,
    output logic           pend_lvl,
    output logic [TSW-1:0] pend_ts,
    output logic           drop
);
    logic [1:0]          sync;
    logic [FILT_LEN-1:0] taps;
    logic                filt, filt_q, evt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync   <= '0;
            taps   <= '0;
            filt   <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            sync   <= {sync[0], din};
            taps   <= {taps[FILT_LEN-2:0], sync[1]};
            if (&taps)
                filt <= 1'b1;
            else if (~|taps)
                filt <= 1'b0;
            filt_q <= filt;
        end
    end

    // At the startup edge every enabled channel reports its level once, whatever the edge type.
    always_comb begin
        if (startup_evt)
            evt = |mode;
        else
            evt = det_en & ((mode[0] & filt & ~filt_q) | (mode[1] & ~filt & filt_q));
    end

    assign drop = evt & pend_v & ~grant;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_v   <= 1'b0;
            pend_lvl <= 1'b0;
            pend_ts  <= '0;
        end else if (evt && (!pend_v || grant)) begin
            pend_v   <= 1'b1;
            pend_lvl <= filt;
            pend_ts  <= ts;
        end else if (grant) begin
            pend_v <= 1'b0;
        end
    end
endmodule

module lost_chanbank #(
    parameter int NCHAN      = 8,
    parameter int FILT_LEN   = 3,
    parameter int DEPTH_LOG2 = 4,
    localparam int CHW       = $clog2(NCHAN)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NCHAN-1:0]      datain,
    input  logic [2*NCHAN-1:0]    edgemode,
    input  logic [63:0]           counterin,
    input  logic                  unload,
    input  logic [2:0]            byteaddr,
    input  logic [NCHAN-1:0]      clearoverrun,
`ifdef LOST_DROPCNT_EN
    input  logic [CHW-1:0]        dropsel,
`endif
    output logic [7:0]            dataout,
    output logic [DEPTH_LOG2:0]   itemsinfifo,
    output logic [NCHAN-1:0]      overrun,
`ifdef LOST_DROPCNT_EN
    output logic [7:0]            dropcnt,
`endif
    output logic                  attention
);
    localparam int TSW     = 63 - CHW;
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int STARTUP = FILT_LEN + 4;
    localparam int SUW     = $clog2(STARTUP + 1);

    typedef struct packed {
        logic [TSW-1:0] ts;
        logic [CHW-1:0] chan;
        logic           lvl;
    } word_t;

    logic [SUW-1:0]              st_cnt;
    logic                        startup_evt, det_en;
    logic [NCHAN-1:0]            pend_v, pend_lvl, drop, gnt_oh;
    logic [NCHAN-1:0][TSW-1:0]   pend_ts;
    logic [CHW-1:0]              rr, gnt_idx, cand;
    logic                        gnt_v, full, empty, can_wr, pop;
    logic [63:0]                 mem [DEPTH];
    logic [DEPTH_LOG2-1:0]       wptr, rptr;
    logic [DEPTH_LOG2:0]         count;
    logic [63:0]                 head;
    word_t                       wr_word;
    logic                        unused_ts_hi;

    assign unused_ts_hi = ^counterin[63:TSW];

    assign startup_evt = (st_cnt == SUW'(STARTUP - 1));
    assign det_en      = (st_cnt == SUW'(STARTUP));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            st_cnt <= '0;
        else if (!det_en)
            st_cnt <= st_cnt + 1'b1;
    end

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        lost_chan #(.FILT_LEN(FILT_LEN), .TSW(TSW)) u_chan (
            .clk         (clk),
            .rstn        (rstn),
            .din         (datain[g]),
            .mode        (edgemode[2*g +: 2]),
            .ts          (counterin[TSW-1:0]),
            .startup_evt (startup_evt),
            .det_en      (det_en),
            .grant       (gnt_oh[g]),
            .pend_v      (pend_v[g]),
            .pend_lvl    (pend_lvl[g]),
            .pend_ts     (pend_ts[g]),
            .drop        (drop[g])
        );
    end

    assign full   = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty  = (count == '0);
    assign can_wr = !full || unload;   // a pop on a full FIFO frees the slot this same edge
    assign pop    = unload && !empty;

    always_comb begin
        gnt_v   = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        cand    = '0;
        for (int i = 0; i < NCHAN; i++) begin
            cand = CHW'((int'(rr) + i) % NCHAN);
            if (can_wr && !gnt_v && pend_v[cand]) begin
                gnt_v   = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_v)
            gnt_oh[gnt_idx] = 1'b1;
    end

    assign wr_word = {pend_ts[gnt_idx], gnt_idx, pend_lvl[gnt_idx]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rr        <= '0;
            overrun   <= '0;
            attention <= 1'b0;
        end else begin
            if (gnt_v) begin
                mem[wptr] <= wr_word;
                wptr      <= wptr + 1'b1;
                rr        <= (gnt_idx == CHW'(NCHAN - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            case ({gnt_v, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            overrun   <= (overrun & ~clearoverrun) | drop;
            attention <= !empty || (|overrun);
        end
    end

    assign head        = mem[rptr];
    assign dataout     = head[{byteaddr, 3'b000} +: 8];
    assign itemsinfifo = count;

`ifdef LOST_DROPCNT_EN
    logic [NCHAN-1:0][7:0] dcnt;

    // A drop in the same cycle as a clear still counts, like the overrun flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dcnt <= '0;
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (clearoverrun[i])
                    dcnt[i] <= drop[i] ? 8'd1 : 8'd0;
                else if (drop[i] && dcnt[i] != 8'hff)
                    dcnt[i] <= dcnt[i] + 1'b1;
            end
        end
    end

    assign dropcnt = dcnt[dropsel];
`endif
endmodule

// File: tb/tb_lost_chanbank.sv
// Randomized bench for lost_chanbank against a sample-window / queue reference model.
`timescale 1ns/1ps
module tb_lost_chanbank;
    localparam int NCHAN      = 8;
    localparam int FILT_LEN   = 3;
    localparam int DEPTH_LOG2 = 4;
    localparam int CHW        = $clog2(NCHAN);
    localparam int TSW        = 63 - CHW;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int STARTUP    = FILT_LEN + 4;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic [NCHAN-1:0]      datain = '0;
    logic [2*NCHAN-1:0]    edgemode = '1;
    logic [63:0]           counterin = '0;
    logic                  unload = 1'b0;
    logic [2:0]            byteaddr = '0;
    logic [NCHAN-1:0]      clearoverrun = '0;
    logic [7:0]            dataout;
    logic [DEPTH_LOG2:0]   itemsinfifo;
    logic [NCHAN-1:0]      overrun;
    logic                  attention;
`ifdef LOST_DROPCNT_EN
    logic [CHW-1:0]        dropsel = '0;
    logic [7:0]            dropcnt;
`endif

    lost_chanbank #(.NCHAN(NCHAN), .FILT_LEN(FILT_LEN), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .datain       (datain),
        .edgemode     (edgemode),
        .counterin    (counterin),
        .unload       (unload),
        .byteaddr     (byteaddr),
        .clearoverrun (clearoverrun),
`ifdef LOST_DROPCNT_EN
        .dropsel      (dropsel),
        .dropcnt      (dropcnt),
`endif
        .dataout      (dataout),
        .itemsinfifo  (itemsinfifo),
        .overrun      (overrun),
        .attention    (attention)
    );

    always #10 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: raw samples and filtered levels indexed by edge number since reset.
    logic [NCHAN-1:0] smp[$];
    logic [NCHAN-1:0] fl[$];
    logic [63:0]      q[$];
    int               ecnt;
    bit               pv[NCHAN];
    bit               plv[NCHAN];
    logic [TSW-1:0]   pts[NCHAN];
    int               rr_m;
    logic [NCHAN-1:0] ovr_m;
    bit               att_m;
    int               dcnt_m[NCHAN];
    logic [63:0]      head_w;

    function automatic logic [NCHAN-1:0] samp(input int e);
        return (e < 1) ? '0 : smp[e-1];
    endfunction

    function automatic logic [NCHAN-1:0] flt(input int e);
        return (e < 1) ? '0 : fl[e-1];
    endfunction

    task automatic model_reset();
        smp.delete();
        fl.delete();
        q.delete();
        ecnt  = 0;
        rr_m  = 0;
        ovr_m = '0;
        att_m = 1'b0;
        for (int c = 0; c < NCHAN; c++) begin
            pv[c] = 0; plv[c] = 0; pts[c] = '0; dcnt_m[c] = 0;
        end
    endtask

    task automatic model_edge();
        logic [NCHAN-1:0] newf, prevf, cur, old, s, evt, lvl;
        logic [1:0]       m;
        bit               all1, all0, att_n, drp;
        int               g, c;
        att_n = (q.size() != 0) || (ovr_m != '0);
        ecnt++;
        smp.push_back(datain);
        prevf = flt(ecnt - 1);
        for (int ch = 0; ch < NCHAN; ch++) begin
            all1 = 1; all0 = 1;
            for (int e = ecnt - FILT_LEN - 2; e <= ecnt - 3; e++) begin
                s = samp(e);
                if (s[ch]) all0 = 0; else all1 = 0;
            end
            newf[ch] = all1 ? 1'b1 : (all0 ? 1'b0 : prevf[ch]);
        end
        fl.push_back(newf);
        cur = flt(ecnt - 1);
        old = flt(ecnt - 2);
        evt = '0;
        lvl = cur;
        for (int ch = 0; ch < NCHAN; ch++) begin
            m = edgemode[2*ch +: 2];
            if (ecnt == STARTUP)
                evt[ch] = (m != 2'b00);
            else if (ecnt > STARTUP && cur[ch] != old[ch])
                evt[ch] = cur[ch] ? m[0] : m[1];
        end
        g = -1;
        if (q.size() < DEPTH || unload) begin
            for (int i = 0; i < NCHAN; i++) begin
                c = (rr_m + i) % NCHAN;
                if (g < 0 && pv[c]) g = c;
            end
        end
        if (unload && q.size() > 0) void'(q.pop_front());
        if (g >= 0) begin
            q.push_back({pts[g], CHW'(g), plv[g]});
            rr_m = (g + 1) % NCHAN;
        end
        for (int ch = 0; ch < NCHAN; ch++) begin
            drp = 0;
            if (evt[ch]) begin
                if (!pv[ch] || ch == g) begin
                    pv[ch] = 1; plv[ch] = lvl[ch]; pts[ch] = counterin[TSW-1:0];
                end else begin
                    drp = 1;
                end
            end else if (ch == g) begin
                pv[ch] = 0;
            end
            if (clearoverrun[ch]) begin ovr_m[ch] = 1'b0; dcnt_m[ch] = 0; end
            if (drp) begin
                ovr_m[ch] = 1'b1;
                if (dcnt_m[ch] < 255) dcnt_m[ch]++;
            end
        end
        att_m = att_n;
    endtask

    task automatic check_outputs();
        chk("items", 64'(itemsinfifo), 64'(q.size()));
        chk("overrun", 64'(overrun), 64'(ovr_m));
        chk("attention", 64'(attention), 64'(att_m));
        if (q.size() > 0) begin
            for (int b = 0; b < 8; b++) begin
                byteaddr = 3'(b);
                #1;
                head_w[8*b +: 8] = dataout;
            end
            chk("head_word", head_w, q[0]);
        end
`ifdef LOST_DROPCNT_EN
        dropsel = CHW'($urandom_range(0, NCHAN - 1));
        #1;
        chk("dropcnt", 64'(dropcnt), 64'(dcnt_m[dropsel]));
`endif
    endtask

    task automatic cycle(input logic [NCHAN-1:0] din, input bit unl, input logic [NCHAN-1:0] clr);
        datain       = din;
        unload       = unl;
        clearoverrun = clr;
        counterin    = counterin + 64'd1;
        @(posedge clk);
        if (rstn) model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset(input logic [NCHAN-1:0] din);
        rstn = 1'b0;
        model_reset();
        #1;
        chk("rst_dataout", 64'(dataout), 64'd0);
        cycle(din, 1'b0, '0);
        cycle(din, 1'b0, '0);
        rstn = 1'b1;
    endtask

    function automatic logic [NCHAN-1:0] toggles(input int odds);
        logic [NCHAN-1:0] t;
        for (int i = 0; i < NCHAN; i++) t[i] = ($urandom_range(0, odds - 1) == 0);
        return t;
    endfunction

    function automatic logic [NCHAN-1:0] rare_clear();
        return ($urandom_range(0, 29) == 0) ? NCHAN'($urandom) : '0;
    endfunction

    logic [NCHAN-1:0] cur_din;
    logic [7:0]       su_lvl;

    initial begin
        counterin = {$urandom, $urandom};
        su_lvl    = 8'h05;
        cur_din   = 8'h05;
        edgemode  = '1;
        @(negedge clk);
        do_reset(cur_din);

        // Startup: every channel reports its steady level once, in channel order.
        repeat (30) cycle(cur_din, 1'b0, '0);
        chk("startup_items", 64'(itemsinfifo), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk("startup_chan", 64'(head_w[CHW:1]), 64'(i));
            chk("startup_lvl", 64'(head_w[0]), 64'(su_lvl[i]));
            cycle(cur_din, 1'b1, '0);
        end
        cycle(cur_din, 1'b1, '0);
        cycle(cur_din, 1'b1, '0);
        chk("empty_unload", 64'(itemsinfifo), 64'd0);

        // Mixed traffic with glitches, random modes and draining.
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) edgemode = 16'($urandom);
            cur_din ^= toggles(5);
            cycle(cur_din, ($urandom_range(0, 9) < 4), rare_clear());
        end

        // Back-pressure with no draining, then heavy draining with clears.
        edgemode = '1;
        for (int n = 0; n < 300; n++) begin
            cur_din ^= toggles(4);
            cycle(cur_din, 1'b0, rare_clear());
        end
        for (int n = 0; n < 100; n++) begin
            cur_din ^= toggles(6);
            cycle(cur_din, 1'b1, rare_clear());
        end

        // Reset in the middle of traffic: the startup sequence must rerun.
        for (int n = 0; n < 40; n++) begin
            cur_din ^= toggles(3);
            cycle(cur_din, ($urandom_range(0, 1) == 0), '0);
        end
        cur_din  = 8'h05;
        edgemode = '1;
        do_reset(cur_din);
        repeat (30) cycle(cur_din, 1'b0, '0);
        chk("restart_items", 64'(itemsinfifo), 64'd8);

        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 0) edgemode = 16'($urandom);
            cur_din ^= toggles(5);
            cycle(cur_din, ($urandom_range(0, 9) < 3), rare_clear());
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
